rfphoenix_alu_sched: RTL

- Issue scheduler that shares one rfPhoenix ALU between NREQ requesters (thread/warp issue slots).
- Round-robin arbitration, one grant per cycle.
- Two latency classes: short integer/compare/FCMP ops complete in 1 cycle; long FMA-class ops complete in NPIPE cycles.
- Keeps a writeback-slot reservation vector so the single ALU result bus never carries two results in the same cycle.
- Returns each result with its requester index and tag.

---
 rtl/rfphoenix_alu_sched.sv | 100 ++++++++++
 1 files changed

// File: rtl/rfphoenix_alu_sched.sv
// rfphoenix_alu_sched: round-robin ALU issue scheduler with writeback-slot reservation; RFPHOENIX_ALU_SCHED_PERF_EN enables perf_conflicts
module rfphoenix_alu_sched #(
  parameter int NREQ  = 4,
  parameter int NPIPE = 8,
  parameter int TAGW  = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ-1:0]          req_long,
  input  logic [NREQ*TAGW-1:0]     req_tag,
  input  logic                     hold,
  input  logic                     flush,
  output logic [NREQ-1:0]          gnt,
  output logic                     issue_v,
  output logic [$clog2(NREQ)-1:0]  issue_req,
  output logic                     issue_long,
  output logic                     wb_v,
  output logic [$clog2(NREQ)-1:0]  wb_req,
  output logic [TAGW-1:0]          wb_tag,
  output logic [31:0]              perf_conflicts
);
  localparam int IW = $clog2(NREQ);
  logic [NPIPE:0]           res;
  logic [NPIPE:0][IW-1:0]   rq;
  logic [NPIPE:0][TAGW-1:0] tg;
  logic [IW-1:0]            ptr, win, idx;
  logic                     found;
  logic                     blk;
  logic [NREQ-1:0]          elig;
  // A short op would land on the bus where a long op granted NPIPE-1 cycles ago lands
  assign blk  = res[2];
  assign elig = req & (req_long | {NREQ{~blk}}) & {NREQ{~hold & ~flush & ~rst}};
  // First eligible requester at or after the round-robin pointer wins
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int o = 0; o < NREQ; o++) begin
      idx = IW'((int'(ptr) + o) % NREQ);
      if (!found && elig[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end
  assign gnt    = found ? NREQ'(1) << win : '0;
  assign wb_v   = res[0];
  assign wb_req = rq[0];
  assign wb_tag = tg[0];
  // Shift reservations toward the bus, book the granted slot, register the issue
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res        <= '0;
      rq         <= '0;
      tg         <= '0;
      ptr        <= '0;
      issue_v    <= 1'b0;
      issue_req  <= '0;
      issue_long <= 1'b0;
    end else begin
      for (int k = 0; k < NPIPE; k++) begin
        res[k] <= res[k+1];
        if (res[k+1]) begin
          rq[k] <= rq[k+1];
          tg[k] <= tg[k+1];
        end
      end
      res[NPIPE] <= 1'b0;
      issue_v    <= found;
      if (flush) begin
        res <= '0;
      end else if (found) begin
        ptr        <= win == IW'(NREQ-1) ? '0 : win + 1'b1;
        issue_req  <= win;
        issue_long <= req_long[win];
        if (req_long[win]) begin
          res[NPIPE] <= 1'b1;
          rq[NPIPE]  <= win;
          tg[NPIPE]  <= req_tag[win*TAGW +: TAGW];
        end else begin
          res[1] <= 1'b1;
          rq[1]  <= win;
          tg[1]  <= req_tag[win*TAGW +: TAGW];
        end
      end
    end
  end
`ifdef RFPHOENIX_ALU_SCHED_PERF_EN
  logic conflict;
  assign conflict = |(req & ~req_long) & ~hold & ~flush & blk;
  // Saturating count of cycles where a short request lost only to a booked slot
  always_ff @(posedge clk or posedge rst) begin
    if (rst) perf_conflicts <= '0;
    else if (conflict && perf_conflicts != 32'hFFFF_FFFF) perf_conflicts <= perf_conflicts + 32'd1;
  end
`else
  assign perf_conflicts = '0;
`endif
endmodule
